// File: rtl/serial_fa_ctrl.sv
// rtl/serial_fa_ctrl.sv - bit-serial add/subtract controller around a shared one-bit full-adder cell
// One operand pair is processed LSB-first, one bit per cycle, with a registered carry.

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_fa_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry_reg;
   logic             c_msb_in;
   logic [CW-1:0]    cnt;
   logic             cell_s;
   logic             cell_c;

   fa_cell u_cell (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry_reg),
      .s  (cell_s),
      .co (cell_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         res_sh    <= '0;
         carry_reg <= 1'b0;
         c_msb_in  <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  // subtract is A + ~B + 1, so cin is replaced by the forced 1
                  a_sh      <= op_a;
                  b_sh      <= sub ? ~op_b : op_b;
                  carry_reg <= sub ? 1'b1 : cin;
                  cnt       <= '0;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               res_sh    <= {cell_s, res_sh[WIDTH-1:1]};
               a_sh      <= a_sh >> 1;
               b_sh      <= b_sh >> 1;
               carry_reg <= cell_c;
               if (cnt == LAST_BIT) begin
                  // carry into the MSB, needed for the overflow decode in DONE
                  c_msb_in <= carry_reg;
                  state    <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign result    = res_sh;
   assign cout      = carry_reg;
   assign ovf       = c_msb_in ^ carry_reg;

endmodule

// File: tb/tb_serial_fa_ctrl.sv
// tb/tb_serial_fa_ctrl.sv - directed self-checking bench for serial_fa_ctrl
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_serial_fa_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   int n_checks = 0;
   int n_pass   = 0;

   serial_fa_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // accept at the next rising edge, then return on the falling edge where out_valid is first seen
   task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 input logic c, input string tag);
      int cyc;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      op_a = ~a; op_b = ~b;
      cyc = 0;
      while (cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (out_valid) break;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd8);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                         input logic [7:0] er, input logic ec, input logic eo, input string tag);
      start_and_wait(a, b, s, c, tag);
      check({tag, "_result"}, 32'(result), 32'(er));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] held_res;
      logic       held_c;
      logic       held_o;
      int         accept_cyc[$];
      int         cyc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, "add");
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "carry");
      run_op(8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "cin");
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos");
      run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_neg");
      run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");
      run_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");

      // backpressure: DONE held for 5 cycles while inputs wiggle
      start_and_wait(8'h7F, 8'h01, 1'b0, 1'b0, "bp");
      held_res = result; held_c = cout; held_o = ovf;
      check("bp_result0", 32'(held_res), 32'h80);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         op_a = 8'(i * 37); op_b = 8'(i * 11); sub = ~sub;
         @(posedge clk);
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_result", 32'(result), 32'h80);
         check("bp_cout", 32'(cout), 32'(held_c));
         check("bp_ovf", 32'(ovf), 32'd1);
      end
      in_valid = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      check("bp_in_ready_hs", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_idle", 32'(in_ready), 32'd1);
      check("bp_out_valid_low", 32'(out_valid), 32'd0);

      // back-to-back with both handshakes tied high
      op_a = 8'h11; op_b = 8'h22; sub = 1'b0; cin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (cyc = 0; cyc < 32; cyc++) begin
         if (in_ready) accept_cyc.push_back(cyc);
         if (out_valid) check("b2b_result", 32'(result), 32'h33);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("b2b_accepts", 32'(accept_cyc.size()), 32'd4);
      for (int i = 1; i < accept_cyc.size(); i++)
         check("b2b_period", 32'(accept_cyc[i] - accept_cyc[i-1]), 32'd10);
      while (!in_ready && cyc < 100) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      check("b2b_drain", 32'(in_ready), 32'd1);

      // asynchronous reset after three bits have been processed
      op_a = 8'hFF; op_b = 8'h00; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      check("arst_cout", 32'(cout), 32'd0);
      check("arst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_fa_ctrl.md
# serial_fa_ctrl

Bit-serial add/subtract controller that time-shares one one-bit full-adder cell across all WIDTH bits of an operand pair. It captures operands through a valid/ready handshake and sequences them LSB-first through the cell, one bit per cycle, with a registered carry. It presents the WIDTH-bit result with carry-out and signed overflow through a second valid/ready handshake. It is the area-minimal alternative to a ripple chain of full-adder cells in the adder datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- op_a  input  WIDTH  operand A, unsigned or two's complement.
- op_b  input  WIDTH  operand B.
- sub  input  1  1 = A − B, 0 = A + B + cin.
- cin  input  1  carry-in for add; ignored when sub=1.
- out_valid  output  1  result, cout and ovf are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load a_sh ← op_a and b_sh ← (sub ? ~op_b : op_b).
  - Set carry_reg ← (sub ? 1 : cin) and bit counter ← 0, then go to RUN.
- RUN, one bit per cycle:
  - The cell computes {c, s} = a_sh[0] + b_sh[0] + carry_reg.
  - result shifts right with s entering at bit WIDTH−1.
  - a_sh and b_sh shift right; carry_reg ← c; counter increments.
  - When counter = WIDTH−1, latch c_msb_in ← carry_reg before the update.
  - Go to DONE on the same edge that processes bit WIDTH−1.
- DONE:
  - out_valid=1; cout=carry_reg; ovf = c_msb_in XOR carry_reg.
  - result, cout and ovf are held stable until out_ready; on out_valid && out_ready, go to IDLE.
- Inputs outside the IDLE accept edge are ignored. Operands may change freely after acceptance.
- While out_valid=0, the values of result, cout and ovf are unspecified; the bench checks them only while out_valid=1.
- The counter is $clog2(WIDTH) bits wide and never wraps within an operation.
- The block does not overlap operations: in_ready stays 0 through RUN and DONE, even in a DONE cycle where out_ready=1.

## Timing
- Reset (rst_n low, takes effect asynchronously):
  - State IDLE.
  - in_ready=1; out_valid=0; result=0; cout=0; ovf=0.
  - Internal shift registers, carry_reg and counter = 0.
- Reset release is synchronous to the next clk edge.
- Reset asserted mid-RUN or mid-DONE abandons the operation immediately, with no output handshake.
- Latency: operands accepted at edge 0 give RUN on edges 1..WIDTH; out_valid rises after edge WIDTH.
- Minimum issue period is WIDTH+2 cycles: output handshake at edge WIDTH+1, IDLE for one cycle, next accept at edge WIDTH+2.
- Backpressure: out_ready low holds DONE indefinitely with all outputs constant.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.

## Test plan
- Add, WIDTH=8: op_a=0x3C, op_b=0x05, cin=0 → result 0x41, cout=0, ovf=0. out_valid rises exactly 8 cycles after the accept edge.
- Carry out: 0xFF+0x01, cin=0 → 0x00, cout=1, ovf=0. Also 0xFF+0x00 with cin=1 → 0x00, cout=1.
- Signed overflow: 0x7F+0x01 → 0x80, cout=0, ovf=1. Also 0x80+0x80 → 0x00, cout=1, ovf=1.
- Subtract: 0x05−0x07 → 0xFE, cout=0, ovf=0. Also 0x80−0x01 → 0x7F, cout=1, ovf=1. cin is driven 1 throughout and must have no effect.
- Handshake and backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid, result, cout and ovf stay constant.
  - in_ready stays 0 and toggling in_valid and operands has no effect.
  - Assert out_ready → IDLE, with in_ready=1 the next cycle.
  - Back-to-back ops with in_valid and out_ready tied high → accepts every 10 cycles.
- Reset mid-operation: pull rst_n low during RUN at bit 3 → outputs reach their reset values without waiting for a clk edge. After release, a new op 0x12+0x34 → 0x46 with correct latency.
